hazard_controller: RTL

//  Central hazard/sequencing controller for the 5-stage MIPS pipeline. Drives the

---
 rtl/mips_pkg.sv | 7 +
 rtl/hazard_controller_if.sv | 19 +
 rtl/md_sequencer.sv | 40 ++++
 rtl/hazard_controller.sv | 45 ++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared forwarding encodings and MULT/DIV sequencer states
package mips_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: pipeline <-> hazard unit signal bundle
// master: pipeline side (drives register ids/controls, receives selects/stalls)
// slave:  hazard controller side
interface hazard_controller_if #(parameter int REG_W = 5);
  logic [REG_W-1:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic branchD, regWriteE, memToRegE, regWriteM, memToRegM, regWriteW, mdStartE;
  logic [1:0] forwardAE, forwardBE;
  logic forwardAD, forwardBD, stallF, stallD, stallE, flushE, mdBusy, mdDone;
  modport master(
    output rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
    output branchD, regWriteE, memToRegE, regWriteM, memToRegM, regWriteW, mdStartE,
    input forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, stallE, flushE, mdBusy, mdDone
  );
  modport slave(
    input rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
    input branchD, regWriteE, memToRegE, regWriteM, memToRegM, regWriteW, mdStartE,
    output forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, stallE, flushE, mdBusy, mdDone
  );
endinterface

// File: rtl/md_sequencer.sv
// md_sequencer: MULT/DIV occupancy FSM (IDLE -> BUSY x MD_CYCLES-1 -> DONE)
// ports: clk, reset (sync, active-high), start (accepted in IDLE only),
//        busy (in BUSY), done (one cycle in DONE)
module md_sequencer
  import mips_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(MD_CYCLES - 2);
  md_state_t state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stateNext = state == IDLE ? (start ? BUSY : IDLE)
              : state == BUSY ? (cnt == '0 ? DONE : BUSY)
              : IDLE;
    cntNext   = (state == IDLE && start) ? LOAD
              : (state == BUSY && cnt != '0) ? cnt - CW'(1)
              : cnt;
  end
  assign busy = state == BUSY;
  assign done = state == DONE;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: forwarding selects, load-use/branch stalls and MULT/DIV hold
// ports: clk, reset (sync, active-high), hz (hazard_controller_if.slave):
//        register ids/write controls in, forward selects, stallF/D/E, flushE,
//        mdBusy, mdDone out
module hazard_controller
  import mips_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int REG_W     = 5
) (
  input logic clk,
  input logic reset,
  hazard_controller_if.slave hz
);
  logic mdBusy, mdDone, mdHold, lwStall, brStall;
  function automatic logic hit(input logic we, input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return we && dst != '0 && dst == src;
  endfunction
  md_sequencer #(.MD_CYCLES(MD_CYCLES)) uMd (
    .clk(clk),
    .reset(reset),
    .start(hz.mdStartE),
    .busy(mdBusy),
    .done(mdDone)
  );
  // Memory stage wins over Writeback: it holds the younger value
  assign hz.forwardAE = hit(hz.regWriteM, hz.writeRegM, hz.rsE) ? FWD_MEM
                      : hit(hz.regWriteW, hz.writeRegW, hz.rsE) ? FWD_WB : FWD_RF;
  assign hz.forwardBE = hit(hz.regWriteM, hz.writeRegM, hz.rtE) ? FWD_MEM
                      : hit(hz.regWriteW, hz.writeRegW, hz.rtE) ? FWD_WB : FWD_RF;
  assign hz.forwardAD = hit(hz.regWriteM, hz.writeRegM, hz.rsD);
  assign hz.forwardBD = hit(hz.regWriteM, hz.writeRegM, hz.rtD);
  assign lwStall = hit(hz.memToRegE && hz.regWriteE, hz.writeRegE, hz.rsD)
                || hit(hz.memToRegE && hz.regWriteE, hz.writeRegE, hz.rtD);
  assign brStall = hz.branchD && (hit(hz.regWriteE, hz.writeRegE, hz.rsD) || hit(hz.regWriteE, hz.writeRegE, hz.rtD)
                || hit(hz.memToRegM, hz.writeRegM, hz.rsD) || hit(hz.memToRegM, hz.writeRegM, hz.rtD));
  // Freeze F/D/E on the issue cycle too; a start seen in DONE is not yet accepted
  assign mdHold    = mdBusy || (hz.mdStartE && !mdDone);
  assign hz.stallF = !reset && (mdHold || lwStall || brStall);
  assign hz.stallD = !reset && (mdHold || lwStall || brStall);
  assign hz.stallE = !reset && mdHold;
  assign hz.flushE = !reset && !mdHold && (lwStall || brStall);
  assign hz.mdBusy = mdBusy;
  assign hz.mdDone = mdDone;
endmodule
